// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues instruction-memory requests, captures returned
// words into a registered output stage backed by a one-entry skid buffer, tags each
// instruction with a wrapping sequence number and handles taken-branch redirects,
// including a request that is still in flight when the redirect arrives.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [3:0]  TYPE_NONE = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_wpcir,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  if_ins_type,
    output logic [3:0]  if_ins_number
);

    // FETCH: request outstanding. HOLD: skid full, no request.
    // DRAIN: a redirected request is still in flight; its ack is thrown away.
    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [3:0]  tag_q, tag_d;

    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc4_q, out_pc4_d;
    logic [3:0]  out_type_q, out_type_d;
    logic [3:0]  out_num_q, out_num_d;
    logic        out_valid_q, out_valid_d;

    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [3:0]  skid_type_q, skid_type_d;
    logic [3:0]  skid_num_q, skid_num_d;

    logic        accept;
    logic [31:0] pc_plus4;
    logic [3:0]  word_type;

    // Instruction class from the major opcode field.
    function automatic logic [3:0] classify(input logic [5:0] op);
        logic [3:0] t;
        case (op)
            6'h00:                         t = 4'd1;
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F:    t = 4'd2;
            6'h23:                         t = 4'd3;
            6'h2B:                         t = 4'd4;
            6'h04, 6'h05:                  t = 4'd5;
            6'h02, 6'h03:                  t = 4'd6;
            default:                       t = 4'd7;
        endcase
        return t;
    endfunction

    // Shared helper signals for the next-state logic.
    always_comb begin
        accept    = !out_valid_q || !id_wpcir;
        pc_plus4  = pc_q + 32'd4;
        word_type = classify(imem_rdata[31:26]);
    end

    // Next-state for the FSM, PC, tag counter, output register and skid entry.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        tag_d       = tag_q;
        out_inst_d  = out_inst_q;
        out_pc4_d   = out_pc4_q;
        out_type_d  = out_type_q;
        out_num_d   = out_num_q;
        out_valid_d = out_valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc4_d  = skid_pc4_q;
        skid_type_d = skid_type_q;
        skid_num_d  = skid_num_q;

        if (br_taken) begin
            // Redirect wins over everything: flush both entries to a bubble.
            out_inst_d  = 32'd0;
            out_pc4_d   = 32'd0;
            out_type_d  = TYPE_NONE;
            out_valid_d = 1'b0;
            skid_inst_d = 32'd0;
            skid_pc4_d  = 32'd0;
            skid_type_d = TYPE_NONE;
            skid_num_d  = 4'd0;
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        pc_d    = br_target;
                        state_d = StFetch;
                    end else begin
                        // Keep the in-flight address on the bus until its ack;
                        // the target waits in redir until then.
                        redir_d = br_target;
                        state_d = StDrain;
                    end
                end
                StHold: begin
                    pc_d    = br_target;
                    state_d = StFetch;
                end
                StDrain: begin
                    if (imem_ack) begin
                        pc_d    = br_target;
                        state_d = StFetch;
                    end else begin
                        redir_d = br_target;
                    end
                end
                default: begin
                    pc_d    = br_target;
                    state_d = StFetch;
                end
            endcase
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        pc_d  = pc_plus4;
                        tag_d = tag_q + 4'd1;
                        if (accept) begin
                            out_inst_d  = imem_rdata;
                            out_pc4_d   = pc_plus4;
                            out_type_d  = word_type;
                            out_num_d   = tag_q;
                            out_valid_d = 1'b1;
                        end else begin
                            skid_inst_d = imem_rdata;
                            skid_pc4_d  = pc_plus4;
                            skid_type_d = word_type;
                            skid_num_d  = tag_q;
                            state_d     = StHold;
                        end
                    end else if (accept) begin
                        out_inst_d  = 32'd0;
                        out_pc4_d   = 32'd0;
                        out_type_d  = TYPE_NONE;
                        out_valid_d = 1'b0;
                    end
                end
                StHold: begin
                    // imem_ack is meaningless here since no request is up.
                    if (accept) begin
                        out_inst_d  = skid_inst_q;
                        out_pc4_d   = skid_pc4_q;
                        out_type_d  = skid_type_q;
                        out_num_d   = skid_num_q;
                        out_valid_d = 1'b1;
                        state_d     = StFetch;
                    end
                end
                StDrain: begin
                    if (accept) begin
                        out_inst_d  = 32'd0;
                        out_pc4_d   = 32'd0;
                        out_type_d  = TYPE_NONE;
                        out_valid_d = 1'b0;
                    end
                    // Stale word is dropped and never tagged.
                    if (imem_ack) begin
                        pc_d    = redir_q;
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            redir_q     <= RESET_PC;
            tag_q       <= 4'd0;
            out_inst_q  <= 32'd0;
            out_pc4_q   <= 32'd0;
            out_type_q  <= TYPE_NONE;
            out_num_q   <= 4'd0;
            out_valid_q <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc4_q  <= 32'd0;
            skid_type_q <= TYPE_NONE;
            skid_num_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_q     <= redir_d;
            tag_q       <= tag_d;
            out_inst_q  <= out_inst_d;
            out_pc4_q   <= out_pc4_d;
            out_type_q  <= out_type_d;
            out_num_q   <= out_num_d;
            out_valid_q <= out_valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc4_q  <= skid_pc4_d;
            skid_type_q <= skid_type_d;
            skid_num_q  <= skid_num_d;
        end
    end

    // Request is gated by rst so it drops the moment reset asserts.
    always_comb begin
        imem_req      = !rst && (state_q != StHold);
        imem_addr     = pc_q;
        if_inst       = out_inst_q;
        if_pc4        = out_pc4_q;
        if_ins_type   = out_type_q;
        if_ins_number = out_num_q;
    end

endmodule
